// File: rtl/sram_rd_ctrl.sv
// sram_rd_ctrl: tile read sequencer feeding sram_buffer.
// Walks a rows x cols tile at base + r*stride + c, drives the SRAM port
// combinationally and produces data_vld/row_last aligned with douta_buf.
// Host single-word writes are passed through only while idle.
// Optional build macro SRAM_RD_PERF_EN adds the stall_cnt performance counter.

module sram_rd_ctrl #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned CNT_W  = 8,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clka,
   input  logic              rstn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  rows,
   input  logic [CNT_W-1:0]  cols,
   input  logic [ADDR_W-1:0] stride,
   input  logic              stall,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   output logic              ena,
   output logic              wea,
   output logic [ADDR_W-1:0] addra,
   output logic              data_vld,
   output logic              row_last,
   output logic              busy,
   output logic              done,
`ifdef SRAM_RD_PERF_EN
   output logic [15:0]       stall_cnt,
`endif
   output logic              wr_drop
);

   localparam int unsigned DrainW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

   typedef enum logic [1:0] {
      StIdle,
      StRead,
      StDrain,
      StDone
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    rows_q, rows_d;
   logic [CNT_W-1:0]    cols_q, cols_d;
   logic [ADDR_W-1:0]   stride_q, stride_d;
   logic [CNT_W-1:0]    r_q, r_d;
   logic [CNT_W-1:0]    c_q, c_d;
   logic [ADDR_W-1:0]   row_base_q, row_base_d;
   logic [DrainW-1:0]   drain_q, drain_d;
   logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
   logic [RD_LAT-1:0]   last_pipe_q, last_pipe_d;
   logic                wr_drop_q, wr_drop_d;

   logic                issue;
   logic                col_end;
   logic                row_end;
   logic                start_acc;

   assign start_acc = (state_q == StIdle) && start;
   assign issue     = (state_q == StRead) && !stall;
   assign col_end   = (c_q == cols_q - CNT_W'(1));
   assign row_end   = (r_q == rows_q - CNT_W'(1));

   // SRAM port: host write in idle (start has priority), otherwise tile reads
   always_comb begin
      ena   = 1'b0;
      wea   = 1'b0;
      addra = '0;
      if ((state_q == StIdle) && host_we && !start) begin
         ena   = 1'b1;
         wea   = 1'b1;
         addra = host_addr;
      end else if (issue) begin
         ena   = 1'b1;
         addra = row_base_q + ADDR_W'(c_q);
      end
   end

   // Next-state: tile walk, drain timer and config capture
   always_comb begin
      state_d    = state_q;
      rows_d     = rows_q;
      cols_d     = cols_q;
      stride_d   = stride_q;
      r_d        = r_q;
      c_d        = c_q;
      row_base_d = row_base_q;
      drain_d    = drain_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               rows_d     = rows;
               cols_d     = cols;
               stride_d   = stride;
               r_d        = '0;
               c_d        = '0;
               row_base_d = base_addr;
               // Empty tile skips straight to completion without touching SRAM
               if ((rows == '0) || (cols == '0)) begin
                  state_d = StDone;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead: begin
            if (issue) begin
               if (col_end) begin
                  c_d        = '0;
                  r_d        = r_q + CNT_W'(1);
                  row_base_d = row_base_q + stride_q;
                  if (row_end) begin
                     state_d = StDrain;
                     drain_d = '0;
                  end
               end else begin
                  c_d = c_q + CNT_W'(1);
               end
            end
         end
         StDrain: begin
            // Hold until the last issued read has reached douta_buf
            if (drain_q == DrainW'(RD_LAT - 1)) begin
               state_d = StDone;
            end else begin
               drain_d = drain_q + DrainW'(1);
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Valid/row-last delay lines matching the BRAM + sram_buffer latency
   always_comb begin
      vld_pipe_d     = '0;
      last_pipe_d    = '0;
      vld_pipe_d[0]  = issue;
      last_pipe_d[0] = issue && col_end;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         vld_pipe_d[i]  = vld_pipe_q[i-1];
         last_pipe_d[i] = last_pipe_q[i-1];
      end
   end

   // A host write is lost whenever it cannot be granted the SRAM port
   always_comb begin
      wr_drop_d = host_we && ((state_q != StIdle) || start);
   end

   // State and datapath registers
   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         state_q     <= StIdle;
         rows_q      <= '0;
         cols_q      <= '0;
         stride_q    <= '0;
         r_q         <= '0;
         c_q         <= '0;
         row_base_q  <= '0;
         drain_q     <= '0;
         vld_pipe_q  <= '0;
         last_pipe_q <= '0;
         wr_drop_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         cols_q      <= cols_d;
         stride_q    <= stride_d;
         r_q         <= r_d;
         c_q         <= c_d;
         row_base_q  <= row_base_d;
         drain_q     <= drain_d;
         vld_pipe_q  <= vld_pipe_d;
         last_pipe_q <= last_pipe_d;
         wr_drop_q   <= wr_drop_d;
      end
   end

   assign data_vld = vld_pipe_q[RD_LAT-1];
   assign row_last = last_pipe_q[RD_LAT-1];
   assign busy     = (state_q == StRead) || (state_q == StDrain);
   assign done     = (state_q == StDone);
   assign wr_drop  = wr_drop_q;

`ifdef SRAM_RD_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of stalled READ cycles, restarted per tile
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (start_acc) begin
         stall_cnt_d = '0;
      end else if ((state_q == StRead) && stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // Performance counter register
   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`else
   logic unused_start_acc;
   assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_sram_rd_ctrl.sv
// Testbench for sram_rd_ctrl: tiles with directed and random stall patterns are
// compared against an address list and timing model derived from the tile rules.

module tb_sram_rd_ctrl;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned RD_LAT = 2;

   logic              clka = 1'b0;
   logic              rstn = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [CNT_W-1:0]  rows = '0;
   logic [CNT_W-1:0]  cols = '0;
   logic [ADDR_W-1:0] stride = '0;
   logic              stall = 1'b0;
   logic              host_we = 1'b0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic              ena, wea, data_vld, row_last, busy, done, wr_drop;
   logic [ADDR_W-1:0] addra;
`ifdef SRAM_RD_PERF_EN
   logic [15:0]       stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clka = ~clka;

   sram_rd_ctrl #(
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W),
      .RD_LAT(RD_LAT)
   ) dut (
      .clka     (clka),
      .rstn     (rstn),
      .start    (start),
      .base_addr(base_addr),
      .rows     (rows),
      .cols     (cols),
      .stride   (stride),
      .stall    (stall),
      .host_we  (host_we),
      .host_addr(host_addr),
      .ena      (ena),
      .wea      (wea),
      .addra    (addra),
      .data_vld (data_vld),
      .row_last (row_last),
      .busy     (busy),
      .done     (done),
`ifdef SRAM_RD_PERF_EN
      .stall_cnt(stall_cnt),
`endif
      .wr_drop  (wr_drop)
   );

   // Run one tile. stall_mode: 0 none, 1 stall on READ cycles 2 and 4, 2 random.
   // inj_cyc: cycle (relative to start at 0) carrying host_we (and a start if >0); -1 none.
   task automatic run_tile(input string name, input logic [ADDR_W-1:0] b,
                           input int r, input int c, input logic [ADDR_W-1:0] s,
                           input int stall_mode, input int inj_cyc);
      logic [ADDR_W-1:0] exp_q[$];
      logic [ADDR_W-1:0] exp_a;
      bit                issued_at[int];
      int                total, issued, last_issue, vld_cnt, stalls, exp_done;
      bit                exp_busy, exp_vld, exp_rl, finished;
      total      = r * c;
      issued     = 0;
      last_issue = -100;
      vld_cnt    = 0;
      stalls     = 0;
      finished   = 1'b0;
      for (int rr = 0; rr < r; rr++) begin
         for (int cc = 0; cc < c; cc++) begin
            exp_q.push_back(ADDR_W'(int'(b) + rr * int'(s) + cc));
         end
      end
      @(negedge clka);
      start     = 1'b1;
      base_addr = b;
      rows      = CNT_W'(r);
      cols      = CNT_W'(c);
      stride    = s;
      stall     = 1'b0;
      host_we   = (inj_cyc == 0);
      host_addr = 10'h2AA;
      #1;
      checks++;
      if (ena !== 1'b0) $display("FAIL %s start_cycle_ena: got %b want 0", name, ena);
      if (ena !== 1'b0) errors++;
      for (int k = 1; k <= 300 && !finished; k++) begin
         @(negedge clka);
         start   = (k == inj_cyc);
         host_we = (k == inj_cyc);
         if (k == inj_cyc) begin
            base_addr = 10'h155;
            rows      = 8'd3;
            cols      = 8'd3;
         end
         stall = (issued < total) &&
                 ((stall_mode == 1 && (k == 2 || k == 4)) ||
                  (stall_mode == 2 && $urandom_range(0, 2) == 0));
         if (stall) stalls++;
         #1;
         exp_busy = (total > 0) && ((issued < total) || (k <= last_issue + int'(RD_LAT)));
         checks++;
         if (busy !== exp_busy) begin
            errors++;
            $display("FAIL %s busy@%0d: got %b want %b", name, k, busy, exp_busy);
         end
         if (stall) begin
            checks++;
            if (ena !== 1'b0) begin
               errors++;
               $display("FAIL %s stall_ena@%0d: got %b want 0", name, k, ena);
            end
         end
         if (ena === 1'b1) begin
            checks++;
            if (wea !== 1'b0) begin
               errors++;
               $display("FAIL %s wea@%0d: got %b want 0", name, k, wea);
            end
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s extra_issue@%0d: got addr %h want none", name, k, addra);
            end else begin
               exp_a = exp_q.pop_front();
               if (addra !== exp_a) begin
                  errors++;
                  $display("FAIL %s addra@%0d: got %h want %h", name, k, addra, exp_a);
               end
            end
            issued++;
            last_issue   = k;
            issued_at[k] = 1'b1;
         end
         exp_vld = issued_at.exists(k - int'(RD_LAT));
         exp_rl  = 1'b0;
         if (exp_vld) begin
            vld_cnt++;
            exp_rl = (vld_cnt % c) == 0;
         end
         checks++;
         if (data_vld !== exp_vld || row_last !== exp_rl) begin
            errors++;
            $display("FAIL %s vld/row_last@%0d: got %b/%b want %b/%b",
                     name, k, data_vld, row_last, exp_vld, exp_rl);
         end
         checks++;
         if (wr_drop !== (inj_cyc >= 0 && k == inj_cyc + 1)) begin
            errors++;
            $display("FAIL %s wr_drop@%0d: got %b want %b", name, k, wr_drop,
                     (inj_cyc >= 0 && k == inj_cyc + 1));
         end
         exp_done = (total == 0) ? 1 :
                    ((issued == total) ? last_issue + int'(RD_LAT) + 1 : -1);
         checks++;
         if (done !== (k == exp_done)) begin
            errors++;
            $display("FAIL %s done@%0d: got %b want %b", name, k, done, (k == exp_done));
         end
         if (k == exp_done) finished = 1'b1;
         if (k == 300 && !finished) begin
            errors++;
            $display("FAIL %s timeout: got no done within 300 cycles, want done", name);
         end
      end
      @(negedge clka);
      start   = 1'b0;
      host_we = 1'b0;
      stall   = 1'b0;
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || issued != total) begin
         errors++;
         $display("FAIL %s tail: got done=%b busy=%b issued=%0d want 0/0/%0d",
                  name, done, busy, issued, total);
      end
      if (total > 0) begin
         checks++;
         if (last_issue != total + stalls) begin
            errors++;
            $display("FAIL %s read_cycles: got last issue %0d want %0d",
                     name, last_issue, total + stalls);
         end
      end
`ifdef SRAM_RD_PERF_EN
      checks++;
      if (stall_cnt !== 16'(stalls)) begin
         errors++;
         $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt, stalls);
      end
`endif
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clka);
      #1;
      checks++;
      if ({ena, wea, addra, data_vld, row_last, busy, done, wr_drop} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got ena=%b wea=%b addra=%h vld=%b rl=%b busy=%b done=%b drop=%b want all 0",
                  ena, wea, addra, data_vld, row_last, busy, done, wr_drop);
      end
      @(negedge clka);
      rstn = 1'b1;
   endtask

   task automatic test_host_write();
      @(negedge clka);
      host_we   = 1'b1;
      host_addr = 10'h055;
      #1;
      checks++;
      if (ena !== 1'b1 || wea !== 1'b1 || addra !== 10'h055) begin
         errors++;
         $display("FAIL host_write: got ena=%b wea=%b addra=%h want 1/1/055", ena, wea, addra);
      end
      @(negedge clka);
      host_we = 1'b0;
      #1;
      checks++;
      if (wr_drop !== 1'b0 || ena !== 1'b0) begin
         errors++;
         $display("FAIL host_write_after: got drop=%b ena=%b want 0/0", wr_drop, ena);
      end
   endtask

   task automatic test_reset_mid_read();
      @(negedge clka);
      start     = 1'b1;
      base_addr = 10'h100;
      rows      = 8'd3;
      cols      = 8'd4;
      stride    = 10'h010;
      @(negedge clka);
      start = 1'b0;
      repeat (3) @(negedge clka);
      rstn = 1'b0;
      #1;
      checks++;
      if ({ena, wea, addra, data_vld, row_last, busy, done, wr_drop} !== '0) begin
         errors++;
         $display("FAIL reset_mid: got ena=%b addra=%h vld=%b busy=%b done=%b want all 0",
                  ena, addra, data_vld, busy, done);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clka);
         #1;
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_done: got %b want 0", done);
         end
      end
      rstn = 1'b1;
      run_tile("after_reset", 10'h020, 2, 2, 10'h004, 0, -1);
   endtask

   task automatic test_random();
      for (int t = 0; t < 8; t++) begin
         run_tile("random", ADDR_W'($urandom), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 5)), ADDR_W'($urandom), 2, -1);
      end
   endtask

   initial begin
      test_reset();
      run_tile("basic", 10'h010, 2, 3, 10'h008, 0, -1);
      run_tile("stall", 10'h010, 2, 3, 10'h008, 1, -1);
      run_tile("wrap", 10'h3FE, 1, 4, 10'h000, 0, -1);
      run_tile("cols_zero", 10'h040, 3, 0, 10'h008, 0, -1);
      test_host_write();
      run_tile("collide_start", 10'h080, 1, 2, 10'h004, 0, 0);
      run_tile("host_in_read", 10'h010, 2, 3, 10'h008, 0, 2);
      test_reset_mid_read();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
